// File: rtl/hash_verify_if.sv
// ============================================================================
//  Module      : hash_verify_if
//  Description : Handshake bundle for hash_verify. It carries the message and
//                expected-digest input channel and the computed-digest result
//                channel, each with its own valid/ready pair.
//                master : the side that supplies messages and consumes results
//                slave  : the verifier itself
//  Ports       : in_valid, in_ready, message[127:0], expected[31:0],
//                out_valid, out_ready, hash_out[31:0], match
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hash_verify_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] message;
    logic [31:0]  expected;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  hash_out;
    logic         match;

    modport master (
        output in_valid, message, expected, out_ready,
        input  in_ready, out_valid, hash_out, match
    );

    modport slave (
        input  in_valid, message, expected, out_ready,
        output in_ready, out_valid, hash_out, match
    );
endinterface

`default_nettype wire

// File: rtl/hash_verify.sv
// ============================================================================
//  Module      : hash_verify
//  Description : Sequential checker for the 32-bit message hash. It latches a
//                128-bit message and an expected digest, recomputes the digest
//                one 32-bit word per clock over four rounds
//                (h = rotl32(h ^ w, 5) + KCONST), then publishes the digest and
//                a match flag and counts mismatches (saturating).
//  Ports       : clk        - system clock, rising edge
//                reset      - synchronous active-high reset
//                bus        - hash_verify_if.slave (input and result channels)
//                err_count  - saturating count of completed mismatches
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hash_verify (
    input  wire logic       clk,
    input  wire logic       reset,
    hash_verify_if.slave    bus,
    output logic [7:0]      err_count
);

    localparam logic [31:0] INIT   = 32'h811C9DC5;
    localparam logic [31:0] KCONST = 32'h9E3779B9;

    // FINISH is the compare/publish cycle after the fourth round, which puts
    // the result on the fifth edge after accept.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUND  = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t       state;
    logic [127:0] msg_q;
    logic [31:0]  exp_q;
    logic [31:0]  h;
    logic [1:0]   r;

    logic [31:0]  word;
    logic [31:0]  mix;
    logic [31:0]  h_next;

    // Word 0 is the most significant 32 bits of the message.
    always_comb begin
        word = 32'h0;
        case (r)
            2'd0:    word = msg_q[127:96];
            2'd1:    word = msg_q[95:64];
            2'd2:    word = msg_q[63:32];
            default: word = msg_q[31:0];
        endcase
        mix    = h ^ word;
        h_next = {mix[26:0], mix[31:27]} + KCONST;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            msg_q         <= 128'h0;
            exp_q         <= 32'h0;
            h             <= 32'h0;
            r             <= 2'd0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.hash_out  <= 32'h0;
            bus.match     <= 1'b0;
            err_count     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        msg_q        <= bus.message;
                        exp_q        <= bus.expected;
                        h            <= INIT;
                        r            <= 2'd0;
                        bus.in_ready <= 1'b0;
                        state        <= ROUND;
                    end
                end
                ROUND: begin
                    h <= h_next;
                    r <= r + 2'd1;
                    if (r == 2'd3) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.hash_out  <= h;
                    bus.match     <= (h == exp_q);
                    bus.out_valid <= 1'b1;
                    // Counted here only, so a long DONE never recounts.
                    if ((h != exp_q) && (err_count != 8'hFF)) begin
                        err_count <= err_count + 8'd1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    // hash_out and match intentionally keep their values.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hash_verify.sv
// ============================================================================
//  Module      : tb_hash_verify
//  Description : Self-checking bench for hash_verify. Vector table plus
//                hand-written sequences for backpressure, input disturbance,
//                mid-operation reset and counter saturation. Expected results
//                are queued when a check is issued and compared when the DUT
//                presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hash_verify;

    localparam logic [31:0] INIT   = 32'h811C9DC5;
    localparam logic [31:0] KCONST = 32'h9E3779B9;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] err_count;

    hash_verify_if bus ();

    hash_verify dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] msg;
        logic [31:0]  exp;
        logic [31:0]  hash;
        logic         match;
        int           hold;
    } vec_t;

    typedef struct {
        logic [31:0] hash;
        logic        match;
        logic [7:0]  err;
    } sb_t;

    sb_t  sb[$];
    int   tests = 0;
    int   fails = 0;
    logic [7:0] err_model = 8'h00;

    function automatic logic [31:0] model(input logic [127:0] m);
        logic [31:0] hv, w, x;
        hv = INIT;
        for (int i = 0; i < 4; i++) begin
            w  = m[127 - 32*i -: 32];
            x  = hv ^ w;
            hv = {x[26:0], x[31:27]} + KCONST;
        end
        return hv;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Scoreboard side: a result is compared once, in the cycle its handshake completes.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                sb_t it;
                it = sb.pop_front();
                chk("hash_out", bus.hash_out, it.hash);
                chk("match", {31'd0, bus.match}, {31'd0, it.match});
                chk("err_count", {24'd0, err_count}, {24'd0, it.err});
            end
        end
    end

    task automatic do_check(input logic [127:0] m, input logic [31:0] e,
                            input logic [31:0] hv, input logic mt,
                            input int hold, input bit disturb);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.message   = m;
        bus.expected  = e;
        bus.out_ready = (hold == 0);
        if (!mt && err_model != 8'hFF) err_model = err_model + 8'd1;
        sb.push_back('{hash: hv, match: mt, err: err_model});
        @(posedge clk); #1;                    // accept edge E0
        chk("in_ready_drop", {31'd0, bus.in_ready}, 32'd0);
        if (!disturb) bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            if (disturb) begin
                bus.message  = {$urandom, $urandom, $urandom, $urandom};
                bus.expected = $urandom;
                chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
            end
            @(posedge clk); #1; n++;
        end
        chk("latency", n, 32'd5);
        bus.in_valid = 1'b0;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("hold_hash", bus.hash_out, hv);
            chk("hold_match", {31'd0, bus.match}, {31'd0, mt});
            chk("hold_err", {24'd0, err_count}, {24'd0, err_model});
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;                    // handshake edge
        chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("kept_hash", bus.hash_out, hv);
    endtask

    vec_t vt[6];

    initial begin
        logic [127:0] m;
        logic [31:0]  hv;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.message   = 128'h0;
        bus.expected  = 32'h0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_hash", bus.hash_out, 32'h0);
        chk("rst_match", {31'd0, bus.match}, 32'd0);
        chk("rst_err", {24'd0, err_count}, 32'd0);
        reset = 1'b0;

        vt[0] = '{128'h0, 32'hDC42782B, 32'hDC42782B, 1'b1, 0};
        vt[1] = '{128'h0, 32'hDC42782A, 32'hDC42782B, 1'b0, 0};
        m = 128'h0123456789ABCDEF_FEDCBA9876543210;
        vt[2] = '{m, model(m), model(m), 1'b1, 0};
        m = {4{32'hFFFFFFFF}};
        vt[3] = '{m, model(m) ^ 32'h8000_0000, model(m), 1'b0, 0};
        m = 128'hDEADBEEF_00000001_CAFEF00D_80000000;
        vt[4] = '{m, model(m), model(m), 1'b1, 3};
        // Backpressure on a mismatch: counted once despite 10 held cycles.
        vt[5] = '{128'h0, 32'h0, 32'hDC42782B, 1'b0, 10};

        for (int i = 0; i < 6; i++) begin
            do_check(vt[i].msg, vt[i].exp, vt[i].hash, vt[i].match, vt[i].hold, 1'b0);
        end

        // Input disturbance while busy, in_valid held high throughout.
        do_check(128'h0, 32'hDC42782B, 32'hDC42782B, 1'b1, 0, 1'b1);

        // Reset during the third round cycle (err_count is nonzero here).
        bus.in_valid = 1'b1;
        bus.message  = 128'h0;
        bus.expected = 32'h0;
        @(posedge clk); #1;                    // E0
        bus.in_valid = 1'b0;
        @(posedge clk); #1;                    // E1
        @(posedge clk); #1;                    // E2
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_hash", bus.hash_out, 32'h0);
        chk("mid_rst_err", {24'd0, err_count}, 32'd0);
        reset = 1'b0;
        sb.delete();
        err_model = 8'h00;
        do_check(128'h0, 32'hDC42782B, 32'hDC42782B, 1'b1, 0, 1'b0);

        // Saturation of the mismatch counter.
        for (int i = 0; i < 257; i++) begin
            m  = {$urandom, $urandom, $urandom, $urandom};
            hv = model(m);
            do_check(m, hv ^ 32'h1, hv, 1'b0, 0, 1'b0);
        end
        chk("err_saturated", {24'd0, err_count}, 32'hFF);
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
